// File: rtl/score_keeper_if.sv
// Button and score bundle between the scoreboard front panel and score_keeper.
// Buttons flow master -> slave; BCD score digits and the change event flow back.
`timescale 1ns/1ps
interface score_keeper_if;
  logic       p1_inc_i;
  logic       p1_dec_i;
  logic       p2_inc_i;
  logic       p2_dec_i;
  logic       clear_i;
  logic [3:0] p1_tens_o;
  logic [3:0] p1_ones_o;
  logic [3:0] p2_tens_o;
  logic [3:0] p2_ones_o;
  logic       score_evt_o;

  modport master (
    output p1_inc_i, p1_dec_i, p2_inc_i, p2_dec_i, clear_i,
    input  p1_tens_o, p1_ones_o, p2_tens_o, p2_ones_o, score_evt_o
  );

  modport slave (
    input  p1_inc_i, p1_dec_i, p2_inc_i, p2_dec_i, clear_i,
    output p1_tens_o, p1_ones_o, p2_tens_o, p2_ones_o, score_evt_o
  );
endinterface

// File: rtl/score_keeper.sv
// Debounces five raw buttons and keeps two saturating 2-digit BCD scores.
// Each debounced press yields one update; score_evt_o pulses after any change.
`timescale 1ns/1ps
module score_keeper #(
  parameter int unsigned DEBOUNCE_MS = 20
) (
  input  logic          clk_1khz,
  input  logic          rst_i,
  score_keeper_if.slave bus
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_MS - 1);

  // Button order: {clear, p2_dec, p2_inc, p1_dec, p1_inc}
  logic [4:0] raw;
  logic [4:0] s1, s2, stable, armed, press;
  logic [7:0] cnt [5];
  logic [1:0] fill;

  assign raw = {bus.clear_i, bus.p2_dec_i, bus.p2_inc_i, bus.p1_dec_i, bus.p1_inc_i};

  // armed blocks a press from a button held across reset; it is set only once the
  // synchroniser carries real samples (fill) and the button is seen low and settled low.
  always_ff @(posedge clk_1khz) begin
    if (rst_i) begin
      s1     <= '0;
      s2     <= '0;
      stable <= '0;
      armed  <= '0;
      press  <= '0;
      fill   <= '0;
      for (int unsigned i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      fill  <= {fill[0], 1'b1};
      press <= '0;
      for (int unsigned i = 0; i < 5; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
          press[i]  <= s2[i] & armed[i];
        end else begin
          cnt[i] <= cnt[i] + 8'd1;
        end
        if (fill[1] && !s2[i] && !stable[i]) armed[i] <= 1'b1;
      end
    end
  end

  function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic inc, input logic dec);
    logic [7:0] r;
    r = v;
    if (inc && !dec) begin
      if (v[3:0] != 4'd9)      r[3:0] = v[3:0] + 4'd1;
      else if (v[7:4] != 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    end else if (dec && !inc) begin
      if (v[3:0] != 4'd0)      r[3:0] = v[3:0] - 4'd1;
      else if (v[7:4] != 4'd0) r = {v[7:4] - 4'd1, 4'd9};
    end
    return r;
  endfunction

  logic [7:0] p1_score, p2_score, p1_next, p2_next;
  logic       evt;

  always_comb begin
    p1_next = bcd_step(p1_score, press[0], press[1]);
    p2_next = bcd_step(p2_score, press[2], press[3]);
    if (press[4]) begin
      p1_next = '0;
      p2_next = '0;
    end
  end

  always_ff @(posedge clk_1khz) begin
    if (rst_i) begin
      p1_score <= '0;
      p2_score <= '0;
      evt      <= 1'b0;
    end else begin
      p1_score <= p1_next;
      p2_score <= p2_next;
      evt      <= (p1_next != p1_score) || (p2_next != p2_score);
    end
  end

  assign bus.p1_tens_o   = p1_score[7:4];
  assign bus.p1_ones_o   = p1_score[3:0];
  assign bus.p2_tens_o   = p2_score[7:4];
  assign bus.p2_ones_o   = p2_score[3:0];
  assign bus.score_evt_o = evt;

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: a decimal score model pushes the expected
// scores per press; each score_evt_o pulse pops and compares one entry.
`timescale 1ns/1ps
module tb_score_keeper;
  localparam int unsigned DMS  = 20;
  localparam int unsigned HOLD = DMS + 4;

  logic clk_1khz = 1'b0;
  logic rst_i    = 1'b1;

  score_keeper_if bus ();

  score_keeper #(.DEBOUNCE_MS(DMS)) dut (
    .clk_1khz (clk_1khz),
    .rst_i    (rst_i),
    .bus      (bus)
  );

  always #5 clk_1khz = ~clk_1khz;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int m1 = 0;
  int m2 = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int dut_score();
    return (int'(bus.p1_tens_o) * 10 + int'(bus.p1_ones_o)) * 100
         +  int'(bus.p2_tens_o) * 10 + int'(bus.p2_ones_o);
  endfunction

  function automatic int digits_ok();
    return int'(bus.p1_tens_o <= 4'd9 && bus.p1_ones_o <= 4'd9 &&
                bus.p2_tens_o <= 4'd9 && bus.p2_ones_o <= 4'd9);
  endfunction

  always @(negedge clk_1khz) begin
    if (!rst_i && bus.score_evt_o) begin
      if (exp_q.size() == 0) check("spurious_evt", int'(bus.score_evt_o), 0);
      else                   check("score", dut_score(), exp_q.pop_front());
      check("digits_bcd", digits_ok(), 1);
    end
  end

  task automatic drive(input logic [4:0] m);
    bus.p1_inc_i = m[0];
    bus.p1_dec_i = m[1];
    bus.p2_inc_i = m[2];
    bus.p2_dec_i = m[3];
    bus.clear_i  = m[4];
  endtask

  // Mask bits: {clear, p2_dec, p2_inc, p1_dec, p1_inc}
  task automatic model(input logic [4:0] m);
    int n1 = m1;
    int n2 = m2;
    if (m[4]) begin
      n1 = 0;
      n2 = 0;
    end else begin
      if (m[0] && !m[1] && n1 < 99) n1++;
      else if (m[1] && !m[0] && n1 > 0) n1--;
      if (m[2] && !m[3] && n2 < 99) n2++;
      else if (m[3] && !m[2] && n2 > 0) n2--;
    end
    if (n1 != m1 || n2 != m2) exp_q.push_back(n1 * 100 + n2);
    m1 = n1;
    m2 = n2;
  endtask

  task automatic press(input logic [4:0] m);
    model(m);
    drive(m);
    repeat (HOLD) @(negedge clk_1khz);
    drive(5'b0);
    repeat (HOLD) @(negedge clk_1khz);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    drive(5'b0);
    repeat (3) @(negedge clk_1khz);
    rst_i = 1'b0;
    check("reset_score", dut_score(), 0);
    check("reset_evt", int'(bus.score_evt_o), 0);
    repeat (5) @(negedge clk_1khz);

    // Held press: exact latency, single event, no repeats
    model(5'b00001);
    drive(5'b00001);
    repeat (DMS + 2) @(posedge clk_1khz);
    #1 check("latency_before", dut_score(), 0);
    @(posedge clk_1khz);
    #1 check("latency_at", dut_score(), 100);
    check("evt_at_update", int'(bus.score_evt_o), 1);
    @(posedge clk_1khz);
    #1 check("evt_one_cycle", int'(bus.score_evt_o), 0);
    repeat (100 - DMS - 3) @(negedge clk_1khz);
    check("held_no_repeat", dut_score(), 100);
    drive(5'b0);
    repeat (HOLD) @(negedge clk_1khz);

    // Glitches one cycle short of the debounce window
    bus.p2_inc_i = 1'b1;
    repeat (DMS - 1) @(negedge clk_1khz);
    bus.p2_inc_i = 1'b0;
    repeat (5) @(negedge clk_1khz);
    bus.p2_inc_i = 1'b1;
    repeat (DMS - 1) @(negedge clk_1khz);
    bus.p2_inc_i = 1'b0;
    repeat (2 * DMS) @(negedge clk_1khz);
    check("glitch_rejected", dut_score(), 100);

    for (int i = 0; i < 8; i++)  press(5'b00001);
    for (int i = 0; i < 10; i++) press(5'b00001);
    check("p1_19", dut_score(), 1900);
    for (int i = 0; i < 80; i++) press(5'b00001);
    check("p1_99", dut_score(), 9900);
    press(5'b00001);
    check("p1_sat_99", dut_score(), 9900);

    press(5'b10000);
    for (int i = 0; i < 10; i++) press(5'b00001);
    press(5'b00010);
    check("p1_dec_borrow", dut_score(), 900);
    for (int i = 0; i < 9; i++) press(5'b00010);
    press(5'b00010);
    check("p1_sat_00", dut_score(), 0);

    press(5'b00111);
    check("inc_dec_same", dut_score(), 1);

    for (int i = 0; i < 16; i++) press(5'b00101);
    for (int i = 0; i < 26; i++) press(5'b00001);
    check("p1_42_p2_17", dut_score(), 4217);
    press(5'b10100);
    check("clear_wins", dut_score(), 0);
    press(5'b10000);
    check("clear_at_zero", dut_score(), 0);

    // Reset mid-debounce with p1_inc held across reset release
    press(5'b00100);
    press(5'b00100);
    drive(5'b00001);
    repeat (12) @(posedge clk_1khz);
    #1 rst_i = 1'b1;
    repeat (2) @(posedge clk_1khz);
    @(negedge clk_1khz);
    exp_q.delete();
    m1 = 0;
    m2 = 0;
    check("midreset_score", dut_score(), 0);
    check("midreset_evt", int'(bus.score_evt_o), 0);
    rst_i = 1'b0;
    repeat (3 * DMS) @(negedge clk_1khz);
    check("held_through_reset", dut_score(), 0);
    drive(5'b0);
    repeat (2 * DMS) @(negedge clk_1khz);
    press(5'b00001);
    check("repress_after_reset", dut_score(), 100);

    repeat (5) @(negedge clk_1khz);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
